ucsbece154b_icache: RTL
=======================

// Module: ucsbece154b_icache
// PURPOSE
//  Instruction cache: the responder end of the fetch interface. Serves the pipeline's next-PC
//  fetch request (ReadAddress/ReadEnable) and returns Instruction with Ready. Ready=0 stalls fetch.
//  2-way set-associative, LRU replacement, read-only. Misses refill a whole block from
//  instruction memory through a single-request, in-order burst interface.
// PARAMETERS
//  NUM_SETS     8   sets; power of 2
//  BLOCK_WORDS  4   32-bit words per block; power of 2
//  WORD_SIZE    32  data width in bits; fixed at 32
//  Address split: [1:0] byte offset (ignored), then log2(BLOCK_WORDS) word offset,
//  then log2(NUM_SETS) set index, remaining upper bits tag.
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-high
//  ReadEnable      in   1   fetch request valid (driven by ~StallF)
//  ReadAddress     in   32  next fetch PC (PCNewF)
//  Instruction     out  32  fetched instruction
//  Ready           out  1   Instruction valid for the last accepted address
//  MemReadAddress  out  32  block-aligned refill address
//  MemReadRequest  out  1   one-cycle refill request pulse
//  MemDataIn       in   32  refill data word
//  MemDataReady    in   1   MemDataIn valid this cycle
// BEHAVIOUR
//  Reset: all valid bits and LRU bits cleared; state IDLE; Instruction=0, Ready=0,
//   MemReadRequest=0, MemReadAddress=0. Reset at any cycle, including mid-refill, aborts the
//   refill; MemDataReady pulses still arriving afterward are ignored.
//  States: IDLE -> REQ -> REFILL -> IDLE.
//  IDLE, ReadEnable=1: tag compare on ReadAddress across both ways; ReadAddress is latched.
//   Hit: next edge Instruction=data[way][set][word], Ready=1. LRU[set] points to the way not hit.
//   Miss: next edge Ready=0 and state REQ.
//  IDLE, ReadEnable=0: Instruction and Ready hold their values. No lookup. No LRU change.
//  REQ: MemReadRequest=1 for exactly one cycle. MemReadAddress = {latched addr[31:offset],
//   zeros}. Victim way is chosen and frozen: way0 if invalid, else way1 if invalid, else LRU[set].
//   Valid[victim][set] cleared. Next state REFILL, word counter=0.
//  REFILL: each MemDataReady=1 writes MemDataIn to data[victim][set][counter]. Counter
//   increments and wraps at BLOCK_WORDS. Words arrive in order, word 0 first. The word whose
//   index equals the latched word offset is captured into Instruction.
//   On the edge taking word BLOCK_WORDS-1: tag written, valid set, LRU[set]=~victim,
//   Ready=1 and state IDLE.
//   MemDataReady=0 holds state; there is no timeout.
//  ReadEnable is ignored outside IDLE. Ready remains 0 throughout REQ/REFILL.
//  Hit latency 1 cycle. Miss latency = 2 + cycles for BLOCK_WORDS MemDataReady pulses.
//  Both ways matching a tag cannot occur (refill invalidates the victim first). If it does,
//   way0 wins.
// TESTING
//  1 Cold miss at 0x00000000, memory returns 0xA0..0xA3 -> one MemReadRequest with
//    MemReadAddress=0x0; Ready=1 after the 4th word; Instruction=0xA0.
//  2 Then fetch 0x0000000C -> Ready=1 next cycle, Instruction=0xA3, no MemReadRequest.
//  3 Miss at 0x00000008 (word offset 2), data with gaps between MemDataReady pulses ->
//    Instruction is word 2; Ready=1 only after word 3.
//  4 Fill 0x000 and 0x080 (both set 0); hit 0x000; fetch 0x100 -> 0x080's way evicted;
//    0x000 still hits; 0x080 misses.
//  5 Assert reset after the 2nd refill word -> Ready=0, MemReadRequest=0; stray
//    MemDataReady ignored; re-fetch of the same address misses.
//  6 After a hit, hold ReadEnable=0 for 3 cycles while ReadAddress changes ->
//    Instruction/Ready unchanged, no memory traffic.

Source files
------------

// File: rtl/ucsbece154b_icache.sv
// rtl/ucsbece154b_icache.sv - 2-way set-associative read-only instruction cache with LRU and burst refill
module ucsbece154b_icache #(
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int WORD_SIZE   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ReadEnable,
    input  logic [31:0]          ReadAddress,
    output logic [WORD_SIZE-1:0] Instruction,
    output logic                 Ready,
    output logic [31:0]          MemReadAddress,
    output logic                 MemReadRequest,
    input  logic [WORD_SIZE-1:0] MemDataIn,
    input  logic                 MemDataReady
);
    localparam int OFF_BITS = $clog2(BLOCK_WORDS);
    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int TAG_LSB  = 2 + OFF_BITS + IDX_BITS;
    localparam int TAG_BITS = 32 - TAG_LSB;
    localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, REFILL} state_t;

    state_t                         state_q, state_d;
    logic [29:0]                    addr_q, addr_d;
    logic                           victim_q, victim_d;
    logic [OFF_BITS-1:0]            cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]           instr_q, instr_d;
    logic                           ready_q, ready_d;
    logic [31:0]                    mem_addr_q, mem_addr_d;
    logic [1:0][NUM_SETS-1:0]       valid_q, valid_d;
    logic [NUM_SETS-1:0]            lru_q, lru_d;

    logic [TAG_BITS-1:0]            tag_q  [2][NUM_SETS];
    logic [WORD_SIZE-1:0]           data_q [2][NUM_SETS][BLOCK_WORDS];
    logic                           data_we, tag_we;

    logic [IDX_BITS-1:0]            rd_set, lat_set;
    logic [OFF_BITS-1:0]            rd_word, lat_word;
    logic [TAG_BITS-1:0]            rd_tag, lat_tag;
    logic                           hit0, hit1;
    logic                           unused_byte_offset;

    assign rd_set   = ReadAddress[2+OFF_BITS +: IDX_BITS];
    assign rd_word  = ReadAddress[2 +: OFF_BITS];
    assign rd_tag   = ReadAddress[31:TAG_LSB];
    assign lat_set  = addr_q[OFF_BITS +: IDX_BITS];
    assign lat_word = addr_q[0 +: OFF_BITS];
    assign lat_tag  = addr_q[29:TAG_LSB-2];
    assign unused_byte_offset = ^ReadAddress[1:0];

    // Way0 takes priority if both somehow match.
    assign hit0 = valid_q[0][rd_set] && (tag_q[0][rd_set] == rd_tag);
    assign hit1 = valid_q[1][rd_set] && (tag_q[1][rd_set] == rd_tag);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        victim_d   = victim_q;
        cnt_d      = cnt_q;
        instr_d    = instr_q;
        ready_d    = ready_q;
        mem_addr_d = mem_addr_q;
        valid_d    = valid_q;
        lru_d      = lru_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ReadEnable) begin
                    addr_d = ReadAddress[31:2];
                    if (hit0 || hit1) begin
                        ready_d       = 1'b1;
                        instr_d       = hit0 ? data_q[0][rd_set][rd_word] : data_q[1][rd_set][rd_word];
                        lru_d[rd_set] = hit0;
                    end else begin
                        ready_d    = 1'b0;
                        mem_addr_d = {ReadAddress[31:2+OFF_BITS], {(2+OFF_BITS){1'b0}}};
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                // Invalidate the victim now so a half-filled block can never hit.
                if (!valid_q[0][lat_set])      victim_d = 1'b0;
                else if (!valid_q[1][lat_set]) victim_d = 1'b1;
                else                           victim_d = lru_q[lat_set];
                valid_d[victim_d][lat_set] = 1'b0;
                cnt_d   = '0;
                state_d = REFILL;
            end
            REFILL: begin
                if (MemDataReady && !reset) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + OFF_BITS'(1);
                    if (cnt_q == lat_word) instr_d = MemDataIn;
                    if (cnt_q == LAST_WORD) begin
                        tag_we                     = 1'b1;
                        valid_d[victim_q][lat_set] = 1'b1;
                        lru_d[lat_set]             = ~victim_q;
                        ready_d                    = 1'b1;
                        state_d                    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            victim_q   <= 1'b0;
            cnt_q      <= '0;
            instr_q    <= '0;
            ready_q    <= 1'b0;
            mem_addr_q <= '0;
            valid_q    <= '0;
            lru_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            victim_q   <= victim_d;
            cnt_q      <= cnt_d;
            instr_q    <= instr_d;
            ready_q    <= ready_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
            lru_q      <= lru_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[victim_q][lat_set][cnt_q] <= MemDataIn;
        if (tag_we)  tag_q[victim_q][lat_set]         <= lat_tag;
    end

    assign Instruction    = instr_q;
    assign Ready          = ready_q;
    assign MemReadAddress = mem_addr_q;
    assign MemReadRequest = (state_q == REQ);
endmodule
